// File: rtl/intf_chan_stream_buf_if.sv
// Handshake bundle for the multi-channel stream buffer: per-channel inputs and one merged, channel-tagged output.
// INTF_CHAN_LEVEL_EN adds the per-channel fill-level bus.
interface intf_chan_stream_buf_if #(
    parameter int NCHAN = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [NCHAN-1:0]       in_valid;
    logic [NCHAN-1:0]       in_ready;
    logic [NCHAN*WIDTH-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [CW-1:0]          out_chan;
`ifdef INTF_CHAN_LEVEL_EN
    logic [NCHAN*LW-1:0]    level;
`endif

    modport master (
        output in_valid, in_data, out_ready,
`ifdef INTF_CHAN_LEVEL_EN
        input  level,
`endif
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef INTF_CHAN_LEVEL_EN
        output level,
`endif
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/intf_chan_stream_buf.sv
// Per-channel FIFOs merged by a round-robin arbiter into one registered, channel-tagged stream.
// Optional INTF_CHAN_LEVEL_EN exports each channel's registered FIFO count.
module intf_chan_stream_buf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_count;

    // Storage is left unreset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
endmodule

module intf_chan_stream_buf #(
    parameter int NCHAN = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    intf_chan_stream_buf_if.slave bus
);
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [NCHAN-1:0]            w_push;
    logic [NCHAN-1:0]            w_pop;
    logic [NCHAN-1:0]            w_nempty;
    logic [NCHAN-1:0]            w_ready;
    logic [NCHAN-1:0][WIDTH-1:0] w_head;
    logic [NCHAN-1:0][LW-1:0]    w_count;

    logic                        w_free;
    logic                        w_found;
    logic                        w_fire;
    logic [CW-1:0]               w_gnt;
    logic [CW-1:0]               w_idx;

    logic                        r_valid;
    logic [WIDTH-1:0]            r_data;
    logic [CW-1:0]               r_chan;
    logic [CW-1:0]               r_last;

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        // Ready depends only on the registered count, never on out_ready.
        assign w_ready[c]  = (w_count[c] != LW'(DEPTH));
        assign w_nempty[c] = (w_count[c] != '0);
        assign w_push[c]   = bus.in_valid[c] && w_ready[c];
        assign w_pop[c]    = w_fire && (w_gnt == CW'(c));

        intf_chan_stream_buf_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[c]),
            .i_pop   (w_pop[c]),
            .i_data  (bus.in_data[c*WIDTH +: WIDTH]),
            .o_head  (w_head[c]),
            .o_count (w_count[c])
        );

`ifdef INTF_CHAN_LEVEL_EN
        assign bus.level[c*LW +: LW] = w_count[c];
`endif
    end

    assign w_free = !r_valid || bus.out_ready;

    // Scan starts just past the last grant, so the previous winner is checked last.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NCHAN; i++) begin
            w_idx = CW'((int'(r_last) + i) % NCHAN);
            if (!w_found && w_nempty[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_fire = w_free && w_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_last  <= CW'(NCHAN - 1);
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_data  <= w_head[w_gnt];
            r_chan  <= w_gnt;
            r_last  <= w_gnt;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_chan  = r_chan;
endmodule

// File: tb/tb_intf_chan_stream_buf.sv
// Randomised bench for intf_chan_stream_buf against a queue-based reference model.
// Level checks are enabled when INTF_CHAN_LEVEL_EN is defined.
module tb_intf_chan_stream_buf;
    localparam int NCHAN = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    intf_chan_stream_buf_if #(.NCHAN(NCHAN), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    intf_chan_stream_buf #(.NCHAN(NCHAN), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [WIDTH-1:0] q [NCHAN][$];
    logic             m_vld;
    logic [WIDTH-1:0] m_data;
    int               m_chan;
    int               m_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCHAN; c++) q[c].delete();
        m_vld  = 1'b0;
        m_data = '0;
        m_chan = 0;
        m_last = NCHAN - 1;
    endtask

    // One clock of the reference: arbitration sees pre-edge contents, then accepted words are appended.
    task automatic model_step();
        logic             free;
        logic             found;
        logic [NCHAN-1:0] acc;
        int               g;
        free  = !m_vld || bus.out_ready;
        found = 1'b0;
        g     = 0;
        for (int c = 0; c < NCHAN; c++) acc[c] = bus.in_valid[c] && (q[c].size() != DEPTH);
        if (free) begin
            for (int i = 1; i <= NCHAN; i++) begin
                int k;
                k = (m_last + i) % NCHAN;
                if (!found && q[k].size() != 0) begin
                    found = 1'b1;
                    g     = k;
                end
            end
        end
        if (found) begin
            m_data = q[g].pop_front();
            m_chan = g;
            m_vld  = 1'b1;
            m_last = g;
        end else if (m_vld && bus.out_ready) begin
            m_vld = 1'b0;
        end
        for (int c = 0; c < NCHAN; c++)
            if (acc[c]) q[c].push_back(bus.in_data[c*WIDTH +: WIDTH]);
    endtask

    task automatic check_all();
        chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("out_chan", 32'(bus.out_chan), m_chan);
        for (int c = 0; c < NCHAN; c++) begin
            chk($sformatf("in_ready%0d", c), 32'(bus.in_ready[c]), 32'(q[c].size() != DEPTH));
`ifdef INTF_CHAN_LEVEL_EN
            chk($sformatf("level%0d", c), 32'(bus.level[c*LW +: LW]), q[c].size());
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        model_reset();
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();

        // Reset and idle state
        do_reset();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'hF);
        repeat (3) cycle();

        // Single word on channel 2
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0100;
        bus.in_data   = 32'h00A5_0000;
        cycle();
        bus.in_valid  = '0;
        cycle();
        chk("t2_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_data", 32'(bus.out_data), 32'hA5);
        chk("t2_chan", 32'(bus.out_chan), 32'd2);
        cycle();
        chk("t2_drain", 32'(bus.out_valid), 32'd0);

        // Fill channel 0 against a stalled output, then drain
        do_reset();
        begin
            int nxt;
            nxt = 0;
            for (int i = 0; i < 8; i++) begin
                bus.in_valid = 4'b0001;
                bus.in_data  = 32'(nxt);
                @(posedge clk);
                if (bus.in_ready[0]) nxt++;
                model_step();
                @(negedge clk);
                check_all();
            end
            chk("t3_accepts", nxt, DEPTH + 1);
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        repeat (8) cycle();

        // Two words preloaded per channel, then round-robin drain
        do_reset();
        for (int w = 0; w < 2; w++) begin
            bus.in_valid = 4'b1111;
            bus.in_data  = {8'(8'h30 + w), 8'(8'h20 + w), 8'(8'h10 + w), 8'(8'h00 + w)};
            cycle();
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NCHAN * 2; i++) begin
            chk("t4_rr_chan", 32'(bus.out_chan), 32'(i % NCHAN));
            cycle();
        end

        // Toggling out_ready with channels 1 and 3 streaming
        do_reset();
        for (int i = 0; i < 200; i++) begin
            bus.out_ready = i[0];
            bus.in_valid  = {1'($urandom), 1'b0, 1'($urandom), 1'b0};
            bus.in_data   = $urandom;
            cycle();
        end

        // Fully random traffic
        for (int i = 0; i < 2000; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = 4'($urandom);
            bus.in_data   = $urandom;
            cycle();
        end

        // Asynchronous reset with buffered words
        do_reset();
        bus.in_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 32'(8'hC0 + i);
            cycle();
        end
        bus.in_valid = '0;
        chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (10) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
